timer_irq: RTL and testbench
============================

# timer_irq

Memory-mapped interval timer that is the source of the `IRQ` line consumed by the pipeline's control decoder. It sits on the data-memory bus beside data RAM. Software programs a reload value, a counter and a control word; on counter overflow the block latches an interrupt status bit and holds `IRQ` high until software clears it.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: byte address of the TH register. TL is at BASE+4, TCON at BASE+8.
- `PRESCALE`, default 1: core-clock cycles per count tick; legal range ≥1. A value of 1 counts every cycle.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `addr`  in  32: byte address from the EX/MEM ALU result; bits [1:0] are ignored.
- `wdata`  in  32: store data.
- `MemRead`  in  1: load strobe.
- `MemWrite`  in  1: store strobe.
- `rdata`  out  32: read data. Combinational from `addr` and the current registers; 0 when not selected.
- `hit`  out  1: `addr[31:2]` matches one of the three register words. The memory mux uses it to select `rdata` over RAM.
- `IRQ`  out  1: interrupt request to the control decoder, equal to `TCON[1] & TCON[2]`.

## Operation
- Registers, all 32 bits:
  - TH: reload value.
  - TL: counter.
  - TCON: bit0 EN, bit1 IE, bit2 IS; bits [31:3] read as 0 and writes to them are ignored.
- Reset values: TH=0, TL=0, TCON=0, prescaler count=0. Outputs after reset: `IRQ`=0; `rdata`=0 unless a register is addressed; `hit` follows `addr`.
- Write: on `MemWrite & hit`, the addressed register takes `wdata` at the clock edge.
- Read: `MemRead` does not gate `rdata`. Reads have no side effects; reading TCON does not clear IS.
- Prescaler:
  - While EN=1, `pcnt` increments each cycle.
  - When `pcnt==PRESCALE-1`, a tick is produced and `pcnt` returns to 0.
  - While EN=0, `pcnt` is held at 0.
- Counting: on each tick, if TL==32'hFFFF_FFFF then TL←TH (overflow), else TL←TL+1. The increment wraps modulo 2^32 and no carry is kept.
- Overflow: sets IS=1, regardless of IE. IS is sticky and is cleared only by a TCON write with bit2=0.
- `IRQ` is level and stays asserted until software clears IS or IE. The handler runs in kernel mode (PC[31]=1), and the pipeline suppresses re-entry, not this block.
- Simultaneous events, in priority order:
  - Store to TL in the same cycle as a tick: the store wins; no increment or reload that cycle.
  - Store to TH in the same cycle as an overflow: the reload uses the old TH, and the new TH is visible next cycle.
  - Store to TCON with bit2=0 in the same cycle as an overflow: IS ends at 1, so set beats clear and no interrupt is lost. The EN and IE fields still take `wdata`.
  - Store to TCON clearing EN: `pcnt` is forced to 0 next cycle, and any tick in that same cycle still applies.
- Reset mid-count: all registers clear immediately (asynchronous), `IRQ` drops in the same cycle, and `pcnt` restarts at 0.

## Timing
- Write to visible effect: 1 cycle. Registers update at the edge that ends the store's MEM stage.
- Read: 0 cycles, combinational. A load in MEM sees values as of the start of that cycle.
- With EN=1 and PRESCALE=P, TL advances once every P cycles. From TL=TH=X, the first overflow occurs (2^32−X)·P cycles later.
- Overflow to `IRQ`: IS is set at the overflow edge, and `IRQ` is high in the following cycle when IE=1.
- TCON clear write to `IRQ` low: 1 cycle, unless a new overflow coincides.

## Structure
- Shared package (`cpu_defs`) holds:
  - `TIMER_BASE`.
  - Register offsets `TH_OFS=0`, `TL_OFS=4`, `TCON_OFS=8`.
  - TCON bit indices `TCON_EN=0`, `TCON_IE=1`, `TCON_IS=2`.
- One sub-module, `tick_prescaler`. It takes the PRESCALE parameter and `en`, and outputs a one-cycle `tick`.
- Top-level logic covers address decode, register file, reload/increment and the read mux.

## Test plan
- Reset: assert `reset` mid-count with TL=5 and IS=1 → TH, TL and TCON read 0 and `IRQ`=0 within the same cycle.
- Basic overflow:
  - Setup: PRESCALE=1, TH=FFFF_FFFD, TL=FFFF_FFFD, TCON=3.
  - Required TL sequence: FFFF_FFFE, FFFF_FFFF, FFFF_FFFD.
  - Required status: IS=1 after the wrap edge, `IRQ`=1 the next cycle.
  - Then TCON←3 clears IS, and `IRQ`=0 one cycle later.
- Prescaler: PRESCALE=4, EN=1, TL=0 → TL=1 after 4 cycles and TL=3 after 12. Clearing EN at cycle 13 freezes TL at 3.
- Set-beats-clear: TCON←3 (IS=0) in the same cycle as an overflow → TCON reads 7 and `IRQ` stays high.
- Store collision: a TL←0000_0010 store on a tick cycle → TL reads 0000_0010 next cycle, not the incremented value. A TH←0000_0100 store on an overflow cycle → TL reloads the old TH.
- IE masking: overflow with IE=0 → IS=1 and `IRQ`=0. Writing TCON←7 → `IRQ`=1 one cycle later.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// Shared CPU-side definitions for the memory-mapped interval timer:
// register map, TCON bit positions and the word decoder.
package cpu_defs;

    localparam logic [31:0] TIMER_BASE = 32'h4000_0000;

    localparam logic [31:0] TH_OFS   = 32'd0;
    localparam logic [31:0] TL_OFS   = 32'd4;
    localparam logic [31:0] TCON_OFS = 32'd8;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_TH   = 2'd1,
        SEL_TL   = 2'd2,
        SEL_TCON = 2'd3
    } reg_sel_e;

    // Field order makes the packed value line up with the TCON bit indices.
    typedef struct packed {
        logic is;
        logic ie;
        logic en;
    } tcon_t;

    function automatic reg_sel_e decode_word(input logic [31:0] base, input logic [29:0] word);
        logic [31:0] a;
        a = {word, 2'b00};
        if (a == ((base + TH_OFS) & 32'hFFFF_FFFC))   return SEL_TH;
        if (a == ((base + TL_OFS) & 32'hFFFF_FFFC))   return SEL_TL;
        if (a == ((base + TCON_OFS) & 32'hFFFF_FFFC)) return SEL_TCON;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/timer_irq_if.sv
// Data-memory bus slice seen by the timer, plus the interrupt line it drives.
interface timer_irq_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        hit;
    logic        IRQ;

    // No valid/ready pair on this bus: a store (MemWrite with hit) is always
    // accepted and lands at the next rising edge; reads are combinational.
    modport master (
        output addr, wdata, MemRead, MemWrite,
        input  rdata, hit, IRQ
    );

    modport slave (
        input  addr, wdata, MemRead, MemWrite,
        output rdata, hit, IRQ
    );
endinterface

// File: rtl/timer_irq_tick_prescaler.sv
// Divides the core clock into a one-cycle count tick every PRESCALE cycles
// while enabled; the phase counter sits at zero whenever disabled.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt_q, pcnt_d;

    assign tick = en && (pcnt_q == LAST);

    always_comb begin
        pcnt_d = pcnt_q + CW'(1);
        if (!en || tick) pcnt_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pcnt_q <= '0;
        else       pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/timer_irq.sv
// Memory-mapped interval timer: TH reload, TL counter, TCON control/status,
// with a level interrupt held until software clears IS or IE.
module timer_irq
    import cpu_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE,
    parameter int unsigned PRESCALE  = 1
) (
    input logic        clk,
    input logic        reset,
    timer_irq_if.slave bus
);
    reg_sel_e    sel;
    logic        we;
    logic        tick;
    logic        ovf;
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    tcon_t       tcon_q, tcon_d;
    logic        unused_bits;

    assign sel         = decode_word(BASE_ADDR, bus.addr[31:2]);
    assign bus.hit     = (sel != SEL_NONE);
    assign we          = bus.MemWrite && bus.hit;
    assign unused_bits = ^{bus.MemRead, bus.addr[1:0]};

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (tcon_q.en),
        .tick (tick)
    );

    assign ovf = tick && (tl_q == 32'hFFFF_FFFF);

    // Stores override counting on TL; TH reload reads the pre-store value;
    // an overflow sets IS after any TCON store so the event is never lost.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;

        if (tick) tl_d = ovf ? th_q : tl_q + 32'd1;

        if (we && sel == SEL_TH) th_d = bus.wdata;
        if (we && sel == SEL_TL) tl_d = bus.wdata;
        if (we && sel == SEL_TCON) begin
            tcon_d.en = bus.wdata[TCON_EN];
            tcon_d.ie = bus.wdata[TCON_IE];
            tcon_d.is = bus.wdata[TCON_IS];
        end

        if (ovf) tcon_d.is = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (sel)
            SEL_TH:   bus.rdata = th_q;
            SEL_TL:   bus.rdata = tl_q;
            SEL_TCON: bus.rdata = {29'd0, tcon_q};
            default:  bus.rdata = '0;
        endcase
    end

    assign bus.IRQ = tcon_q.ie & tcon_q.is;
endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: two instances (PRESCALE 1 and 4) share one bus stimulus
// and are compared against a cycle-level register model.
`timescale 1ns/1ps
module tb_timer_irq;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'd4;
    localparam logic [31:0] A_TCON = BASE + 32'd8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] t_addr  = '0;
    logic [31:0] t_wdata = '0;
    logic        t_rd    = 1'b0;
    logic        t_we    = 1'b0;

    timer_irq_if bus1();
    timer_irq_if bus4();
    assign bus1.addr = t_addr;  assign bus1.wdata = t_wdata;
    assign bus1.MemRead = t_rd; assign bus1.MemWrite = t_we;
    assign bus4.addr = t_addr;  assign bus4.wdata = t_wdata;
    assign bus4.MemRead = t_rd; assign bus4.MemWrite = t_we;

    timer_irq #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    timer_irq #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    int unsigned m_p[2]   = '{1, 4};
    logic [31:0] m_th[2]  = '{32'd0, 32'd0};
    logic [31:0] m_tl[2]  = '{32'd0, 32'd0};
    logic        m_en[2]  = '{1'b0, 1'b0};
    logic        m_ie[2]  = '{1'b0, 1'b0};
    logic        m_is[2]  = '{1'b0, 1'b0};
    int unsigned m_run[2] = '{0, 0};

    // Register index 0/1/2 for TH/TL/TCON, -1 when the word is not ours.
    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = {a[31:2], 2'b00} - BASE;
        if (off == 32'd0) return 0;
        if (off == 32'd4) return 1;
        if (off == 32'd8) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] model_reg(input int k, input int r);
        case (r)
            0:       return m_th[k];
            1:       return m_tl[k];
            2:       return {29'd0, m_is[k], m_ie[k], m_en[k]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input int k);
        int   w;
        logic tk, ov;
        w  = t_we ? word_of(t_addr) : -1;
        // A count happens on every P-th consecutive enabled cycle.
        tk = m_en[k] && (((m_run[k] + 1) % m_p[k]) == 0);
        ov = tk && (m_tl[k] == 32'hFFFF_FFFF);
        m_run[k] = (m_en[k] && !tk) ? m_run[k] + 1 : 0;
        if (w == 1)      m_tl[k] = t_wdata;
        else if (ov)     m_tl[k] = m_th[k];
        else if (tk)     m_tl[k] = m_tl[k] + 32'd1;
        if (w == 0)      m_th[k] = t_wdata;
        if (w == 2) begin
            m_en[k] = t_wdata[0];
            m_ie[k] = t_wdata[1];
            m_is[k] = t_wdata[2] | ov;
        end else if (ov) begin
            m_is[k] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_th[k] = 0; m_tl[k] = 0; m_en[k] = 0; m_ie[k] = 0; m_is[k] = 0; m_run[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        t_we = 1'b0; t_rd = 1'b0; t_addr = '0; t_wdata = '0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
        t_addr = a; t_wdata = d; t_we = 1'b1; t_rd = 1'b0;
    endtask

    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        drive_write(a, d);
        step();
        drive_idle();
    endtask

    task automatic read_both(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4);
        t_we = 1'b0; t_rd = 1'b1; t_addr = a;
        #1;
        d1 = bus1.rdata; d4 = bus4.rdata;
        t_rd = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] a1, a4;
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        for (int r = 0; r < 3; r++) begin
            read_both(BASE + 32'(4 * r), a1, a4);
            checks++; if (a1 !== 32'd0) begin errors++; $display("FAIL reset_reg%0d dut1 got %h want 0", r, a1); end
            checks++; if (a4 !== 32'd0) begin errors++; $display("FAIL reset_reg%0d dut4 got %h want 0", r, a4); end
        end
        checks++; if (bus1.IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", bus1.IRQ); end
        read_both(A_TCON, a1, a4);
        checks++; if (bus1.hit !== 1'b1) begin errors++; $display("FAIL hit_tcon got %b want 1", bus1.hit); end
        read_both(BASE + 32'd12, a1, a4);
        checks++; if (bus1.hit !== 1'b0 || a1 !== 32'd0) begin
            errors++; $display("FAIL hit_none got hit=%b rdata=%h want hit=0 rdata=0", bus1.hit, a1);
        end

        // Run into TL=5 with IS=1, then reset in the middle of a cycle.
        write_reg(A_TH, 32'd4);
        write_reg(A_TL, 32'hFFFF_FFFF);
        write_reg(A_TCON, 32'd3);
        step();
        step();
        read_both(A_TL, a1, a4);
        checks++; if (a1 !== 32'd5) begin errors++; $display("FAIL midcount_tl got %h want 5", a1); end
        read_both(A_TCON, a1, a4);
        checks++; if (a1 !== 32'd7) begin errors++; $display("FAIL midcount_tcon got %h want 7", a1); end
        reset = 1'b1;
        #1;
        checks++; if (bus1.IRQ !== 1'b0 || bus4.IRQ !== 1'b0) begin
            errors++; $display("FAIL async_reset_irq got %b/%b want 0/0", bus1.IRQ, bus4.IRQ);
        end
        for (int r = 0; r < 3; r++) begin
            read_both(BASE + 32'(4 * r), a1, a4);
            checks++; if (a1 !== 32'd0 || a4 !== 32'd0) begin
                errors++; $display("FAIL async_reset_reg%0d got %h/%h want 0/0", r, a1, a4);
            end
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_overflow();
        logic [31:0] a1, a4, e;
        write_reg(A_TCON, 32'd0);
        write_reg(A_TH, 32'hFFFF_FFFD);
        write_reg(A_TL, 32'hFFFF_FFFD);
        write_reg(A_TCON, 32'd3);
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFD);
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            read_both(A_TL, a1, a4);
            checks++; if (a1 !== e) begin errors++; $display("FAIL ovf_tl_seq got %h want %h", a1, e); end
        end
        read_both(A_TCON, a1, a4);
        checks++; if (a1 !== 32'd7) begin errors++; $display("FAIL ovf_is got tcon=%h want 7", a1); end
        checks++; if (bus1.IRQ !== 1'b1) begin errors++; $display("FAIL ovf_irq got %b want 1", bus1.IRQ); end
        write_reg(A_TCON, 32'd3);
        read_both(A_TCON, a1, a4);
        checks++; if (a1 !== 32'd3 || bus1.IRQ !== 1'b0) begin
            errors++; $display("FAIL ovf_clear got tcon=%h irq=%b want 3/0", a1, bus1.IRQ);
        end
        checks++; if (a4 !== model_reg(1, 2)) begin errors++; $display("FAIL ovf_dut4_tcon got %h want %h", a4, model_reg(1, 2)); end
        write_reg(A_TCON, 32'd0);
    endtask

    task automatic test_prescaler();
        logic [31:0] a1, a4;
        write_reg(A_TCON, 32'd0);
        write_reg(A_TL, 32'd0);
        write_reg(A_TCON, 32'd1);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4 || c == 12) begin
                read_both(A_TL, a1, a4);
                checks++; if (a4 !== 32'(c / 4)) begin
                    errors++; $display("FAIL presc_tl_c%0d got %h want %h", c, a4, 32'(c / 4));
                end
            end
        end
        write_reg(A_TCON, 32'd0);
        repeat (8) step();
        read_both(A_TL, a1, a4);
        checks++; if (a4 !== 32'd3) begin errors++; $display("FAIL presc_freeze got %h want 3", a4); end
        checks++; if (a1 !== 32'd13) begin errors++; $display("FAIL presc_dut1_last_tick got %h want 0000000d", a1); end
    endtask

    task automatic test_set_beats_clear();
        logic [31:0] a1, a4;
        write_reg(A_TCON, 32'd0);
        write_reg(A_TH, 32'hFFFF_FFFE);
        write_reg(A_TL, 32'hFFFF_FFFE);
        write_reg(A_TCON, 32'd3);
        step();
        write_reg(A_TCON, 32'd3);
        read_both(A_TCON, a1, a4);
        checks++; if (a1 !== 32'd7 || bus1.IRQ !== 1'b1) begin
            errors++; $display("FAIL set_beats_clear got tcon=%h irq=%b want 7/1", a1, bus1.IRQ);
        end
        read_both(A_TL, a1, a4);
        checks++; if (a1 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sbc_reload got %h want fffffffe", a1); end
        write_reg(A_TCON, 32'd0);
    endtask

    task automatic test_store_collision();
        logic [31:0] a1, a4;
        write_reg(A_TCON, 32'd0);
        write_reg(A_TL, 32'd5);
        write_reg(A_TCON, 32'd1);
        step();
        write_reg(A_TL, 32'h10);
        read_both(A_TL, a1, a4);
        checks++; if (a1 !== 32'h10) begin errors++; $display("FAIL tl_store_wins got %h want 00000010", a1); end
        step();
        read_both(A_TL, a1, a4);
        checks++; if (a1 !== 32'h11) begin errors++; $display("FAIL tl_after_store got %h want 00000011", a1); end
        write_reg(A_TCON, 32'd0);
        write_reg(A_TH, 32'h55);
        write_reg(A_TL, 32'hFFFF_FFFF);
        write_reg(A_TCON, 32'd1);
        write_reg(A_TH, 32'h100);
        read_both(A_TL, a1, a4);
        checks++; if (a1 !== 32'h55) begin errors++; $display("FAIL reload_old_th got %h want 00000055", a1); end
        read_both(A_TH, a1, a4);
        checks++; if (a1 !== 32'h100) begin errors++; $display("FAIL th_new got %h want 00000100", a1); end
        write_reg(A_TCON, 32'd0);
    endtask

    task automatic test_ie_mask();
        logic [31:0] a1, a4;
        write_reg(A_TCON, 32'd0);
        write_reg(A_TH, 32'd0);
        write_reg(A_TL, 32'hFFFF_FFFF);
        write_reg(A_TCON, 32'd1);
        step();
        read_both(A_TCON, a1, a4);
        checks++; if (a1 !== 32'd5 || bus1.IRQ !== 1'b0) begin
            errors++; $display("FAIL ie_masked got tcon=%h irq=%b want 5/0", a1, bus1.IRQ);
        end
        write_reg(A_TCON, 32'd7);
        checks++; if (bus1.IRQ !== 1'b1) begin errors++; $display("FAIL ie_unmask_irq got %b want 1", bus1.IRQ); end
        write_reg(A_TCON, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a1, a4, v, ra, e1, e4;
        logic        eh;
        for (int it = 0; it < 300; it++) begin
            for (int r = 0; r < 3; r++) begin
                read_both(BASE + 32'(4 * r), a1, a4);
                e1 = model_reg(0, r); e4 = model_reg(1, r);
                checks++; if (a1 !== e1) begin errors++; $display("FAIL rnd_it%0d_reg%0d dut1 got %h want %h", it, r, a1, e1); end
                checks++; if (a4 !== e4) begin errors++; $display("FAIL rnd_it%0d_reg%0d dut4 got %h want %h", it, r, a4, e4); end
            end
            checks++; if (bus1.IRQ !== (m_ie[0] & m_is[0]) || bus4.IRQ !== (m_ie[1] & m_is[1])) begin
                errors++; $display("FAIL rnd_it%0d_irq got %b/%b want %b/%b", it, bus1.IRQ, bus4.IRQ,
                                   m_ie[0] & m_is[0], m_ie[1] & m_is[1]);
            end
            ra = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3))
                                             : 32'($urandom());
            read_both(ra, a1, a4);
            eh = (word_of(ra) >= 0);
            e1 = eh ? model_reg(0, word_of(ra)) : 32'd0;
            checks++; if (bus1.hit !== eh || a1 !== e1) begin
                errors++; $display("FAIL rnd_it%0d_addr %h got hit=%b rdata=%h want hit=%b rdata=%h", it, ra, bus1.hit, a1, eh, e1);
            end
            v = $urandom();
            case ($urandom_range(0, 5))
                2: drive_write(A_TH + 32'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | (v & 32'hF)) : v);
                3: drive_write(A_TL + 32'($urandom_range(0, 3)), 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)));
                4: begin
                    v[0] = ($urandom_range(0, 3) != 0);
                    drive_write(A_TCON + 32'($urandom_range(0, 3)), v);
                end
                5: drive_write(BASE + 32'd12 + 32'(4 * $urandom_range(0, 3)), v);
                default: drive_idle();
            endcase
            step();
            drive_idle();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_basic_overflow();
        test_prescaler();
        test_set_beats_clear();
        test_store_collision();
        test_ie_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
